// File: rtl/me_pkg.sv
`default_nettype none
// me_pkg -- shared motion-estimation datapath defaults, pixel type and sizing helpers.
// Revision 1.0
package me_pkg;

    localparam int ME_BIT_DEPTH       = 8;
    localparam int ME_EDGE_LEN        = 8;
    localparam int ME_PIXELS_IN_BATCH = 16;

    typedef logic [ME_BIT_DEPTH-1:0] pixel_t;

    // A single legal offset still needs a 1-bit port.
    function automatic int offset_width(input int col_pixels, input int pixels_in_batch);
        int span;
        span = col_pixels - pixels_in_batch + 1;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

    function automatic int clamp_offset(input int offset, input int max_offset);
        return (offset > max_offset) ? max_offset : offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_column_slice.sv
`default_nettype none
// ref_column_slice -- selects PIXELS_IN_BATCH consecutive pixels of one column at a row offset.
// Revision 1.0
module ref_column_slice
    import me_pkg::*;
#(
    parameter int BIT_DEPTH       = ME_BIT_DEPTH,
    parameter int COL_PIXELS      = 23,
    parameter int PIXELS_IN_BATCH = ME_PIXELS_IN_BATCH,
    parameter int OFFSET_W        = offset_width(COL_PIXELS, PIXELS_IN_BATCH)
) (
    input  logic [COL_PIXELS*BIT_DEPTH-1:0]      column_i,
    input  logic [OFFSET_W-1:0]                  offset_i,
    output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0] window_o
);

    localparam int MAX_OFF = COL_PIXELS - PIXELS_IN_BATCH;

    always_comb begin
        window_o = '0;
        for (int o = 0; o <= MAX_OFF; o++) begin
            if (int'(offset_i) == o) begin
                window_o = column_i[o*BIT_DEPTH +: PIXELS_IN_BATCH*BIT_DEPTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ref_column_window.sv
`default_nettype none
// ref_column_window -- EDGE_LEN-column sliding reference window with flow control and strip tracking.
// Revision 1.0
module ref_column_window
    import me_pkg::*;
#(
    parameter int BIT_DEPTH       = ME_BIT_DEPTH,
    parameter int EDGE_LEN        = ME_EDGE_LEN,
    parameter int COL_PIXELS      = 23,
    parameter int PIXELS_IN_BATCH = ME_PIXELS_IN_BATCH,
    parameter int STRIP_COLS      = 16,
    parameter int OFFSET_W        = offset_width(COL_PIXELS, PIXELS_IN_BATCH)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic [COL_PIXELS*BIT_DEPTH-1:0]               data_in,
    input  logic                                          col_valid_i,
    output logic                                          col_ready_o,
    input  logic [OFFSET_W-1:0]                           row_offset_i,
    input  logic                                          flush_i,
    output logic [EDGE_LEN*PIXELS_IN_BATCH*BIT_DEPTH-1:0] reference_input_column,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic                                          out_last_o,
    output logic [$clog2(EDGE_LEN+1)-1:0]                 fill_count_o
);

    localparam int COL_W   = COL_PIXELS * BIT_DEPTH;
    localparam int WIN_W   = PIXELS_IN_BATCH * BIT_DEPTH;
    localparam int CNT_W   = $clog2(EDGE_LEN + 1);
    localparam int IDX_W   = (STRIP_COLS > 1) ? $clog2(STRIP_COLS) : 1;
    localparam int MAX_OFF = COL_PIXELS - PIXELS_IN_BATCH;

    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(EDGE_LEN);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(STRIP_COLS - 1);

    logic [COL_W-1:0]    col_q [EDGE_LEN];
    logic [CNT_W-1:0]    fill_q,   fill_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                fresh_q,  fresh_d;
    logic                pend_q,   pend_d;
    logic                w_full;
    logic                w_accept;
    logic                w_handshake;

    assign w_full       = (fill_q == C_FULL);
    assign out_valid_o  = w_full && fresh_q;
    assign out_last_o   = pend_q && out_valid_o;
    // A held window may only be overwritten when it is consumed in the same cycle.
    assign col_ready_o  = !flush_i && !pend_q && (!w_full || !fresh_q || out_ready_i);
    assign w_accept     = col_valid_i && col_ready_o;
    assign w_handshake  = out_valid_o && out_ready_i;
    assign fill_count_o = fill_q;

    always_comb begin
        fill_d   = fill_q;
        idx_d    = idx_q;
        offset_d = offset_q;
        fresh_d  = fresh_q;
        pend_d   = pend_q;
        if (flush_i) begin
            fill_d   = '0;
            idx_d    = '0;
            offset_d = '0;
            fresh_d  = 1'b0;
            pend_d   = 1'b0;
        end else if (w_handshake && pend_q) begin
            fill_d  = '0;
            idx_d   = '0;
            fresh_d = 1'b0;
            pend_d  = 1'b0;
        end else if (w_accept) begin
            if (!w_full) begin
                fill_d = fill_q + CNT_W'(1);
            end
            fresh_d = (fill_d == C_FULL);
            if (idx_q == '0) begin
                offset_d = OFFSET_W'(clamp_offset(int'(row_offset_i), MAX_OFF));
            end
            if (idx_q == C_LAST_IDX) begin
                pend_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (w_handshake) begin
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fill_q   <= '0;
            idx_q    <= '0;
            offset_q <= '0;
            fresh_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            offset_q <= offset_d;
            fresh_q  <= fresh_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < EDGE_LEN; i++) begin
                col_q[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < EDGE_LEN - 1; i++) begin
                col_q[i] <= col_q[i+1];
            end
            col_q[EDGE_LEN-1] <= data_in;
        end
    end

    generate
        for (genvar c = 0; c < EDGE_LEN; c++) begin : g_slice
            ref_column_slice #(
                .BIT_DEPTH       (BIT_DEPTH),
                .COL_PIXELS      (COL_PIXELS),
                .PIXELS_IN_BATCH (PIXELS_IN_BATCH),
                .OFFSET_W        (OFFSET_W)
            ) u_slice (
                .column_i (col_q[c]),
                .offset_i (offset_q),
                .window_o (reference_input_column[c*WIN_W +: WIN_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire
